// File: rtl/seq_det_sched.sv
// seq_det_sched
//   Round-robin scheduler sharing one serial "0110" detector among N_REQ
//   requesters. The granted requester streams FRAME_LEN bits, one per clock.
//   Hits inside the frame are counted, and the result is reported with a
//   one-cycle done strobe.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        per-requester request level
//   x_in       per-requester serial data bit
//   gnt        one-hot grant, zero when no frame is running
//   busy       high whenever the scheduler is not idle
//   z          one-cycle pulse per pattern hit
//   done       one-cycle frame-complete strobe
//   done_id    requester index of the completed frame
//   err        frame was aborted (valid with done)
//   match_cnt  saturating hit count of the last or current frame
module seq_det_sched #(
  parameter int N_REQ     = 4,
  parameter int FRAME_LEN = 8,
  parameter int CNT_W     = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] x_in,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             z,
  output logic             done,
  output logic [ID_W-1:0]  done_id,
  output logic             err,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;
  localparam logic [1:0] S3 = 2'd3;

  localparam logic [7:0]       LAST_BIT = 8'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]    N_REQ_W  = (ID_W+1)'(N_REQ);

  logic [1:0]      state;
  logic [1:0]      det;
  logic [1:0]      det_next;
  logic            hit;
  logic            bit_in;
  logic [ID_W-1:0] cur;
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_next;
  logic [ID_W-1:0] sel;
  logic            any_req;
  logic [7:0]      bit_cnt;

  assign busy     = (state != IDLE);
  assign bit_in   = x_in[cur];
  assign ptr_next = (cur == LAST_ID) ? '0 : cur + ID_W'(1);

  // Round-robin pick: scan offsets from the highest down so the requester
  // closest to ptr (going upward with wrap) is the last one written and wins.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    sel     = ptr;
    any_req = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (ID_W+1)'(i);
      if (sum >= N_REQ_W) begin
        sum = sum - N_REQ_W;
      end
      idx = sum[ID_W-1:0];
      if (req[idx]) begin
        sel     = idx;
        any_req = 1'b1;
      end
    end
  end

  // "0110" detector next-state. A hit leaves the machine in S1 so the
  // trailing 0 can start the next occurrence.
  always_comb begin
    det_next = det;
    hit      = 1'b0;
    case (det)
      S0: det_next = bit_in ? S0 : S1;
      S1: det_next = bit_in ? S2 : S1;
      S2: det_next = bit_in ? S3 : S1;
      S3: begin
        det_next = bit_in ? S0 : S1;
        hit      = ~bit_in;
      end
      default: det_next = S0;
    endcase
  end

  // Scheduler: grant in IDLE, stream the frame in RUN, strobe the result
  // in REPORT. done and done_id are loaded on entry to REPORT, so the
  // strobe lines up with the REPORT cycle. An abort is checked before the
  // last-bit test so it wins when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      det       <= S0;
      cur       <= '0;
      ptr       <= '0;
      bit_cnt   <= '0;
      gnt       <= '0;
      z         <= 1'b0;
      done      <= 1'b0;
      done_id   <= '0;
      err       <= 1'b0;
      match_cnt <= '0;
    end else begin
      z    <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur       <= sel;
            gnt       <= N_REQ'(1) << sel;
            bit_cnt   <= '0;
            match_cnt <= '0;
            err       <= 1'b0;
            det       <= S0;
            state     <= RUN;
          end
        end
        RUN: begin
          if (!req[cur]) begin
            err     <= 1'b1;
            gnt     <= '0;
            done    <= 1'b1;
            done_id <= cur;
            state   <= REPORT;
          end else begin
            det     <= det_next;
            bit_cnt <= bit_cnt + 8'd1;
            if (hit) begin
              z <= 1'b1;
              if (match_cnt != CNT_MAX) begin
                match_cnt <= match_cnt + CNT_W'(1);
              end
            end
            if (bit_cnt == LAST_BIT) begin
              gnt     <= '0;
              done    <= 1'b1;
              done_id <= cur;
              state   <= REPORT;
            end
          end
        end
        REPORT: begin
          ptr   <= ptr_next;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
